// File: rtl/pipe_stage_reg.sv
// -----------------------------------------------------------------------------
// pipe_stage_reg
//
// Reusable elastic register placed between two pipeline stages. It carries an
// opaque payload plus a halt marker from the upstream stage to the downstream
// stage using a valid/ready handshake.
//
// With SKID=1 the stage holds up to two entries (head + skid slot), so in_ready
// comes straight from a flop and never depends on out_ready. With SKID=0 the
// stage is a single register and in_ready is combinational.
//
// The stage also provides:
//   - a synchronous flush that drops every held entry (mispredict / jump),
//   - a sticky halt flag that freezes intake once a halt entry reaches the head,
//   - saturating stall and flush event counters for the debug/perf path.
//
// Parameters:
//   DATA_W   payload width in bits
//   SKID     1 = two-entry skid buffer (registered in_ready), 0 = single entry
//   CNT_W    width of stall_cnt / flush_cnt
//
// Ports:
//   CLK        in   system clock, rising edge
//   nRST       in   asynchronous active-low reset
//   in_valid   in   upstream entry valid
//   in_ready   out  stage can accept an entry this cycle
//   in_data    in   upstream payload
//   in_halt    in   upstream entry is a halt instruction
//   flush      in   discard all held entries
//   out_valid  out  downstream entry valid
//   out_ready  in   downstream accepts the entry
//   out_data   out  payload of the head entry
//   out_halt   out  sticky halt indicator
//   stall_cnt  out  cycles with out_valid=1 and out_ready=0 (saturating)
//   flush_cnt  out  flushes that discarded a valid entry (saturating)
// -----------------------------------------------------------------------------
module pipe_stage_reg #(
    parameter int DATA_W = 64,
    parameter int SKID   = 1,
    parameter int CNT_W  = 16
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_halt,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_halt,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_FULL  = 2'd1,
        ST_SKID  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    state_t             state_q,    state_d;
    logic [DATA_W-1:0]  headData_q, headData_d;
    logic               headHalt_q, headHalt_d;
    logic [DATA_W-1:0]  skidData_q, skidData_d;
    logic               skidHalt_q, skidHalt_d;
    logic               outHalt_q,  outHalt_d;
    logic [CNT_W-1:0]   stallCnt_q, stallCnt_d;
    logic [CNT_W-1:0]   flushCnt_q, flushCnt_d;

    logic inXfer;
    logic outXfer;

    assign out_valid = (state_q != ST_EMPTY);
    assign out_data  = headData_q;
    assign out_halt  = outHalt_q;
    assign stall_cnt = stallCnt_q;
    assign flush_cnt = flushCnt_q;

    assign inXfer  = in_valid && in_ready;
    assign outXfer = out_valid && out_ready;

    // Next-state logic for the entry storage, halt flag and counters.
    // Flush has priority over every transfer: the incoming entry is dropped
    // even though upstream sees it as consumed, while a head that leaves in
    // the same cycle still counts as delivered and is not a discard.
    // The SKID=0 build reuses the same machine; its combinational in_ready
    // never allows an input-only transfer while FULL, so ST_SKID is unreachable.
    always_comb begin
        state_d    = state_q;
        headData_d = headData_q;
        headHalt_d = headHalt_q;
        skidData_d = skidData_q;
        skidHalt_d = skidHalt_q;
        stallCnt_d = stallCnt_q;
        flushCnt_d = flushCnt_q;

        if (out_valid && !out_ready && (stallCnt_q != CNT_MAX)) begin
            stallCnt_d = stallCnt_q + CNT_ONE;
        end

        if (flush) begin
            state_d = ST_EMPTY;
            if (((state_q == ST_FULL) && !outXfer) || (state_q == ST_SKID)) begin
                if (flushCnt_q != CNT_MAX) begin
                    flushCnt_d = flushCnt_q + CNT_ONE;
                end
            end
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (inXfer) begin
                        state_d    = ST_FULL;
                        headData_d = in_data;
                        headHalt_d = in_halt;
                    end
                end
                ST_FULL: begin
                    if (outXfer && inXfer) begin
                        headData_d = in_data;
                        headHalt_d = in_halt;
                    end else if (outXfer) begin
                        state_d = ST_EMPTY;
                    end else if (inXfer) begin
                        state_d    = ST_SKID;
                        skidData_d = in_data;
                        skidHalt_d = in_halt;
                    end
                end
                ST_SKID: begin
                    if (outXfer) begin
                        state_d    = ST_FULL;
                        headData_d = skidData_q;
                        headHalt_d = skidHalt_q;
                    end
                end
                default: begin
                    state_d = ST_EMPTY;
                end
            endcase
        end

        // Halt latches once a halt entry is the presented head; nothing but
        // reset clears it.
        outHalt_d = outHalt_q || ((state_d != ST_EMPTY) && headHalt_d && !flush);
    end

    // State and storage registers; reset empties both slots and clears the
    // visible payload, halt flag and counters.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q    <= ST_EMPTY;
            headData_q <= '0;
            headHalt_q <= 1'b0;
            skidData_q <= '0;
            skidHalt_q <= 1'b0;
            outHalt_q  <= 1'b0;
            stallCnt_q <= '0;
            flushCnt_q <= '0;
        end else begin
            state_q    <= state_d;
            headData_q <= headData_d;
            headHalt_q <= headHalt_d;
            skidData_q <= skidData_d;
            skidHalt_q <= skidHalt_d;
            outHalt_q  <= outHalt_d;
            stallCnt_q <= stallCnt_d;
            flushCnt_q <= flushCnt_d;
        end
    end

    generate
        if (SKID != 0) begin : gSkidReady
            logic inReady_q;

            // Ready is precomputed from the next state so the upstream stage
            // sees a flop output with no path from out_ready.
            always_ff @(posedge CLK or negedge nRST) begin
                if (!nRST) begin
                    inReady_q <= 1'b1;
                end else begin
                    inReady_q <= (state_d != ST_SKID) && !outHalt_d;
                end
            end

            assign in_ready = inReady_q;
        end else begin : gCombReady
            assign in_ready = (!out_valid || out_ready) && !outHalt_q;
        end
    endgenerate

endmodule

// File: tb/tb_pipe_stage_reg.sv
// -----------------------------------------------------------------------------
// tb_pipe_stage_reg
//
// Drives two builds of pipe_stage_reg side by side: dutA (SKID=1, CNT_W=4 so
// saturation is reachable quickly) and dutB (SKID=0, CNT_W=16). Expected
// deliveries are queued by the stimulus; a monitor per DUT pops and compares
// whenever an output transfer is about to happen.
// -----------------------------------------------------------------------------
module tb_pipe_stage_reg;

    logic        CLK;
    logic        nRST;

    logic        inValidA, inHaltA, flushA, outReadyA;
    logic [63:0] inDataA;
    logic        inReadyA, outValidA, outHaltA;
    logic [63:0] outDataA;
    logic [3:0]  stallCntA, flushCntA;

    logic        inValidB, inHaltB, flushB, outReadyB;
    logic [63:0] inDataB;
    logic        inReadyB, outValidB, outHaltB;
    logic [63:0] outDataB;
    logic [15:0] stallCntB, flushCntB;

    logic [64:0] expQA[$];
    logic [64:0] expQB[$];

    int checks = 0;
    int errors = 0;

    pipe_stage_reg #(.DATA_W(64), .SKID(1), .CNT_W(4)) dutA (
        .CLK(CLK), .nRST(nRST),
        .in_valid(inValidA), .in_ready(inReadyA), .in_data(inDataA),
        .in_halt(inHaltA), .flush(flushA),
        .out_valid(outValidA), .out_ready(outReadyA), .out_data(outDataA),
        .out_halt(outHaltA), .stall_cnt(stallCntA), .flush_cnt(flushCntA)
    );

    pipe_stage_reg #(.DATA_W(64), .SKID(0), .CNT_W(16)) dutB (
        .CLK(CLK), .nRST(nRST),
        .in_valid(inValidB), .in_ready(inReadyB), .in_data(inDataB),
        .in_halt(inHaltB), .flush(flushB),
        .out_valid(outValidB), .out_ready(outReadyB), .out_data(outDataB),
        .out_halt(outHaltB), .stall_cnt(stallCntB), .flush_cnt(flushCntB)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic applyStimulus(input int sel, input logic valid, input logic [63:0] data,
                                 input logic halt, input logic fl, input logic ready);
        if (sel == 0) begin
            inValidA = valid; inDataA = data; inHaltA = halt; flushA = fl; outReadyA = ready;
        end else begin
            inValidB = valid; inDataB = data; inHaltB = halt; flushB = fl; outReadyB = ready;
        end
    endtask

    // Output monitors: sample mid-cycle, pop one expectation per transfer.
    always @(negedge CLK) begin
        if (nRST && outValidA && outReadyA) begin
            checks++;
            if (expQA.size() == 0) begin
                errors++;
                $display("[TB] FAIL A_unexpected: got data 0x%0h halt %0b, expected no delivery",
                         outDataA, outHaltA);
            end else begin
                logic [64:0] e;
                e = expQA.pop_front();
                if ({outHaltA, outDataA} !== e) begin
                    errors++;
                    $display("[TB] FAIL A_delivery: got halt %0b data 0x%0h, expected halt %0b data 0x%0h",
                             outHaltA, outDataA, e[64], e[63:0]);
                end
            end
        end
        if (nRST && outValidB && outReadyB) begin
            checks++;
            if (expQB.size() == 0) begin
                errors++;
                $display("[TB] FAIL B_unexpected: got data 0x%0h halt %0b, expected no delivery",
                         outDataB, outHaltB);
            end else begin
                logic [64:0] e;
                e = expQB.pop_front();
                if ({outHaltB, outDataB} !== e) begin
                    errors++;
                    $display("[TB] FAIL B_delivery: got halt %0b data 0x%0h, expected halt %0b data 0x%0h",
                             outHaltB, outDataB, e[64], e[63:0]);
                end
            end
        end
    end

    initial begin
        nRST = 1'b0;
        applyStimulus(0, 1'b0, 64'h0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1, 1'b0, 64'h0, 1'b0, 1'b0, 1'b0);
        repeat (2) @(negedge CLK);

        // Reset state of both builds.
        checkOutput("A_rst_out_valid", 64'(outValidA), 64'h0);
        checkOutput("A_rst_out_data",  outDataA, 64'h0);
        checkOutput("A_rst_out_halt",  64'(outHaltA), 64'h0);
        checkOutput("A_rst_stall_cnt", 64'(stallCntA), 64'h0);
        checkOutput("A_rst_flush_cnt", 64'(flushCntA), 64'h0);
        checkOutput("B_rst_out_valid", 64'(outValidB), 64'h0);
        checkOutput("B_rst_stall_cnt", 64'(stallCntB), 64'h0);
        nRST = 1'b1;
        tick();
        checkOutput("A_rst_in_ready", 64'(inReadyA), 64'h1);
        checkOutput("B_rst_in_ready", 64'(inReadyB), 64'h1);

        // ---- A: streaming 0x1..0x8 with downstream always ready ----
        for (int i = 1; i <= 8; i++) expQA.push_back({1'b0, 64'(i)});
        for (int i = 1; i <= 8; i++) begin
            applyStimulus(0, 1'b1, 64'(i), 1'b0, 1'b0, 1'b1);
            checkOutput($sformatf("A_stream_in_ready_%0d", i), 64'(inReadyA), 64'h1);
            tick();
            checkOutput($sformatf("A_stream_out_valid_%0d", i), 64'(outValidA), 64'h1);
        end
        applyStimulus(0, 1'b0, 64'h0, 1'b0, 1'b0, 1'b1);
        tick();
        checkOutput("A_stream_drained", 64'(outValidA), 64'h0);
        checkOutput("A_stream_stall_cnt", 64'(stallCntA), 64'h0);

        // ---- A: backpressure, 0xA then 0xB with out_ready low ----
        expQA.push_back({1'b0, 64'hA});
        expQA.push_back({1'b0, 64'hB});
        applyStimulus(0, 1'b1, 64'hA, 1'b0, 1'b0, 1'b0);
        tick();
        checkOutput("A_bp_ready_after_1st", 64'(inReadyA), 64'h1);
        applyStimulus(0, 1'b1, 64'hB, 1'b0, 1'b0, 1'b0);
        tick();
        checkOutput("A_bp_ready_after_2nd", 64'(inReadyA), 64'h0);
        applyStimulus(0, 1'b0, 64'h0, 1'b0, 1'b0, 1'b0);
        tick();
        tick();
        checkOutput("A_bp_stall_cnt", 64'(stallCntA), 64'h3);
        checkOutput("A_bp_head", outDataA, 64'hA);
        applyStimulus(0, 1'b0, 64'h0, 1'b0, 1'b0, 1'b1);
        tick();
        tick();
        checkOutput("A_bp_drained", 64'(outValidA), 64'h0);
        checkOutput("A_bp_ready_back", 64'(inReadyA), 64'h1);
        checkOutput("A_bp_stall_final", 64'(stallCntA), 64'h3);

        // ---- A: flush with both slots occupied and 0xC presented ----
        applyStimulus(0, 1'b1, 64'h11, 1'b0, 1'b0, 1'b0);
        tick();
        applyStimulus(0, 1'b1, 64'h12, 1'b0, 1'b0, 1'b0);
        tick();
        applyStimulus(0, 1'b1, 64'hC, 1'b0, 1'b1, 1'b0);
        tick();
        checkOutput("A_flush_out_valid", 64'(outValidA), 64'h0);
        checkOutput("A_flush_cnt_1", 64'(flushCntA), 64'h1);
        applyStimulus(0, 1'b0, 64'h0, 1'b0, 1'b0, 1'b1);
        tick();
        checkOutput("A_flush_no_C", 64'(outValidA), 64'h0);
        checkOutput("A_flush_ready", 64'(inReadyA), 64'h1);
        // Flush while empty discards nothing.
        applyStimulus(0, 1'b0, 64'h0, 1'b0, 1'b1, 1'b1);
        tick();
        checkOutput("A_flush_empty_cnt", 64'(flushCntA), 64'h1);
        // Flush while the head leaves: delivered, not counted; 0x22 dropped.
        expQA.push_back({1'b0, 64'h21});
        applyStimulus(0, 1'b1, 64'h21, 1'b0, 1'b0, 1'b1);
        tick();
        applyStimulus(0, 1'b1, 64'h22, 1'b0, 1'b1, 1'b1);
        tick();
        checkOutput("A_flush_deliver_cnt", 64'(flushCntA), 64'h1);
        checkOutput("A_flush_deliver_valid", 64'(outValidA), 64'h0);
        // Flush of a held single entry counts.
        applyStimulus(0, 1'b1, 64'h31, 1'b0, 1'b0, 1'b0);
        tick();
        applyStimulus(0, 1'b0, 64'h0, 1'b0, 1'b1, 1'b0);
        tick();
        applyStimulus(0, 1'b0, 64'h0, 1'b0, 1'b0, 1'b0);
        checkOutput("A_flush_cnt_2", 64'(flushCntA), 64'h2);
        checkOutput("A_flush_stall_cnt", 64'(stallCntA), 64'h6);

        // ---- A: stall counter saturation (4-bit) ----
        applyStimulus(0, 1'b1, 64'h41, 1'b0, 1'b0, 1'b0);
        tick();
        applyStimulus(0, 1'b0, 64'h0, 1'b0, 1'b0, 1'b0);
        repeat (20) tick();
        checkOutput("A_sat_stall_cnt", 64'(stallCntA), 64'hF);

        // ---- A: asynchronous reset mid-cycle with two entries held ----
        applyStimulus(0, 1'b1, 64'h52, 1'b0, 1'b0, 1'b0);
        tick();
        applyStimulus(0, 1'b0, 64'h0, 1'b0, 1'b0, 1'b0);
        #2;
        nRST = 1'b0;
        #1;
        checkOutput("A_arst_out_valid", 64'(outValidA), 64'h0);
        checkOutput("A_arst_stall_cnt", 64'(stallCntA), 64'h0);
        checkOutput("A_arst_flush_cnt", 64'(flushCntA), 64'h0);
        checkOutput("A_arst_out_halt",  64'(outHaltA), 64'h0);
        @(negedge CLK);
        nRST = 1'b1;
        tick();
        checkOutput("A_arst_ready", 64'(inReadyA), 64'h1);

        // ---- A: halt entry 0x5 followed by 0x6 ----
        expQA.push_back({1'b1, 64'h5});
        applyStimulus(0, 1'b1, 64'h5, 1'b1, 1'b0, 1'b0);
        tick();
        checkOutput("A_halt_set", 64'(outHaltA), 64'h1);
        checkOutput("A_halt_ready", 64'(inReadyA), 64'h0);
        applyStimulus(0, 1'b1, 64'h6, 1'b0, 1'b0, 1'b0);
        tick();
        tick();
        checkOutput("A_halt_held_valid", 64'(outValidA), 64'h1);
        checkOutput("A_halt_held_data", outDataA, 64'h5);
        applyStimulus(0, 1'b1, 64'h6, 1'b0, 1'b0, 1'b1);
        tick();
        checkOutput("A_halt_delivered", 64'(outValidA), 64'h0);
        tick();
        checkOutput("A_halt_no_6", 64'(outValidA), 64'h0);
        applyStimulus(0, 1'b0, 64'h0, 1'b0, 1'b1, 1'b1);
        tick();
        applyStimulus(0, 1'b0, 64'h0, 1'b0, 1'b0, 1'b1);
        checkOutput("A_halt_after_flush", 64'(outHaltA), 64'h1);
        checkOutput("A_halt_ready_after_flush", 64'(inReadyA), 64'h0);

        // ---- B (SKID=0): streaming ----
        for (int i = 1; i <= 8; i++) expQB.push_back({1'b0, 64'(i)});
        for (int i = 1; i <= 8; i++) begin
            applyStimulus(1, 1'b1, 64'(i), 1'b0, 1'b0, 1'b1);
            checkOutput($sformatf("B_stream_in_ready_%0d", i), 64'(inReadyB), 64'h1);
            tick();
        end
        applyStimulus(1, 1'b0, 64'h0, 1'b0, 1'b0, 1'b1);
        tick();
        checkOutput("B_stream_drained", 64'(outValidB), 64'h0);
        checkOutput("B_stream_stall_cnt", 64'(stallCntB), 64'h0);

        // ---- B: backpressure with combinational in_ready ----
        expQB.push_back({1'b0, 64'hA});
        expQB.push_back({1'b0, 64'hB});
        applyStimulus(1, 1'b1, 64'hA, 1'b0, 1'b0, 1'b0);
        tick();
        applyStimulus(1, 1'b1, 64'hB, 1'b0, 1'b0, 1'b0);
        #1;
        checkOutput("B_bp_ready_low", 64'(inReadyB), 64'h0);
        tick();
        tick();
        tick();
        checkOutput("B_bp_stall_cnt", 64'(stallCntB), 64'h3);
        applyStimulus(1, 1'b1, 64'hB, 1'b0, 1'b0, 1'b1);
        #1;
        checkOutput("B_bp_ready_comb", 64'(inReadyB), 64'h1);
        tick();
        applyStimulus(1, 1'b0, 64'h0, 1'b0, 1'b0, 1'b1);
        tick();
        checkOutput("B_bp_drained", 64'(outValidB), 64'h0);
        checkOutput("B_bp_stall_final", 64'(stallCntB), 64'h3);

        tick();
        checkOutput("A_queue_empty", 64'(expQA.size()), 64'h0);
        checkOutput("B_queue_empty", 64'(expQB.size()), 64'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
